// File: rtl/param_alu_core.sv
// param_alu_core: multi-cycle ALU with a GPR file, an SGPR holding the MUL
// upper half, and an iterative or single-cycle multiplier.
module param_alu_core #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 32,
    parameter bit MUL_SEQ = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              illegal,
    output logic [DATA_W-1:0] sgpr,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    logic [1:0]          state;
    logic                rdy_en;
    logic [DATA_W-1:0]   gpr [NREG];

    logic [4:0]          op_q;
    logic [4:0]          rdst_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   sgpr_q;
    logic [DATA_W-1:0]   result_q;
    logic [3:0]          flags_q;
    logic                done_q;
    logic                illegal_q;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] prod_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;

    logic [4:0]          in_op;
    logic [4:0]          in_rdst;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic                in_imm;
    logic [DATA_W-1:0]   src1_val;
    logic [DATA_W-1:0]   src2_val;
    logic [DATA_W-1:0]   dbg_val;
    logic [DATA_W-1:0]   op_b;
    logic                accept;

    logic [DATA_W-1:0]   alu_res;
    logic [DATA_W-1:0]   alu_hi;
    logic                alu_c;
    logic                alu_v;
    logic                alu_legal;
    logic [DATA_W:0]     sum_ext;
    logic [2*DATA_W-1:0] full_prod;

    logic                mul_last;
    logic                exec_wb;
    logic                wb_en;
    logic                wb_hi_en;
    logic [DATA_W-1:0]   wb_val;
    logic [DATA_W-1:0]   wb_hi;
    logic                wb_c;
    logic                wb_v;

    assign in_op   = instr[31:27];
    assign in_rdst = instr[26:22];
    assign in_rs1  = instr[21:17];
    assign in_imm  = instr[16];
    assign in_rs2  = instr[15:11];

    assign instr_ready = rdy_en && (state == S_IDLE);
    assign accept      = instr_valid && instr_ready;

    // Indices beyond NREG match no entry and read as zero.
    always_comb begin
        src1_val = '0;
        src2_val = '0;
        dbg_val  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (in_rs1 == 5'(i)) src1_val = gpr[i];
            if (in_rs2 == 5'(i)) src2_val = gpr[i];
            if (dbg_addr == 5'(i)) dbg_val = gpr[i];
        end
    end

    assign op_b = in_imm ? DATA_W'(instr[15:0]) : src2_val;

    always_comb begin
        alu_res   = '0;
        alu_hi    = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        sum_ext   = '0;
        full_prod = '0;
        case (op_q)
            OP_MOVSGPR: alu_res = sgpr_q;
            OP_MOV:     alu_res = b_q;
            OP_ADD: begin
                sum_ext = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (a_q[MSB] == b_q[MSB]) &&
                          (alu_res[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                sum_ext = {1'b0, a_q} - {1'b0, b_q};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (a_q[MSB] != b_q[MSB]) &&
                          (alu_res[MSB] != a_q[MSB]);
            end
            OP_MUL: begin
                if (!MUL_SEQ) begin
                    full_prod = {{DATA_W{1'b0}}, a_q} *
                                {{DATA_W{1'b0}}, b_q};
                end
                alu_res = full_prod[MSB:0];
                alu_hi  = full_prod[2*DATA_W-1:DATA_W];
                alu_c   = |alu_hi;
            end
            OP_OR:   alu_res = a_q | b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_NAND: alu_res = ~(a_q & b_q);
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_NOT:  alu_res = ~b_q;
            default: alu_legal = 1'b0;
        endcase
    end

    assign mul_last = (state == S_MUL) && (cnt == CNT_W'(DATA_W));
    assign exec_wb  = (state == S_EXEC) && alu_legal;
    assign wb_en    = exec_wb || mul_last;
    assign wb_hi_en = mul_last || (exec_wb && (op_q == OP_MUL));
    assign wb_val   = mul_last ? prod_q[MSB:0] : alu_res;
    assign wb_hi    = mul_last ? prod_q[2*DATA_W-1:DATA_W] : alu_hi;
    assign wb_c     = mul_last ? |prod_q[2*DATA_W-1:DATA_W] : alu_c;
    assign wb_v     = mul_last ? 1'b0 : alu_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rdy_en    <= 1'b0;
            op_q      <= '0;
            rdst_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt       <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            rdy_en    <= 1'b1;
            done_q    <= wb_en;
            illegal_q <= (state == S_EXEC) && !alu_legal;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= in_op;
                        rdst_q <= in_rdst;
                        a_q    <= src1_val;
                        b_q    <= op_b;
                        if ((in_op == OP_MUL) && MUL_SEQ) begin
                            state    <= S_MUL;
                            cnt      <= '0;
                            prod_q   <= '0;
                            mcand_q  <= {{DATA_W{1'b0}}, op_b};
                            mplier_q <= src1_val;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: state <= S_IDLE;
                S_MUL: begin
                    // DATA_W shift-add steps, then one writeback edge
                    if (mul_last) begin
                        state <= S_IDLE;
                    end else begin
                        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt      <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
            sgpr_q   <= '0;
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (wb_en) begin
            result_q <= wb_val;
            flags_q  <= {wb_val[MSB], wb_val == '0, wb_c, wb_v};
            if (wb_hi_en) sgpr_q <= wb_hi;
            for (int i = 0; i < NREG; i++) begin
                if (rdst_q == 5'(i)) gpr[i] <= wb_val;
            end
        end
    end

    assign done     = done_q;
    assign illegal  = illegal_q;
    assign result   = result_q;
    assign flags    = flags_q;
    assign sgpr     = sgpr_q;
    assign dbg_data = dbg_val;

endmodule

// File: tb/tb_param_alu_core.sv
// tb_param_alu_core: directed scoreboard bench for param_alu_core
// (DATA_W=16, NREG=32, MUL_SEQ=1).
module tb_param_alu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        illegal;
    logic [15:0] sgpr;
    logic [4:0]  dbg_addr = '0;
    logic [15:0] dbg_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [15:0] val;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_val = '0;
    logic [3:0]  last_fl = '0;

    param_alu_core #(
        .DATA_W (16),
        .NREG   (32),
        .MUL_SEQ(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .done       (done),
        .result     (result),
        .flags      (flags),
        .illegal    (illegal),
        .sgpr       (sgpr),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fr(input logic [4:0] op,
            input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] fi(input logic [4:0] op,
            input logic [4:0] rd, input logic [4:0] rs1,
            input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic exp_t mk(input logic [4:0] rd,
            input logic [15:0] val, input logic [3:0] fl, input int lat);
        exp_t e;
        e.rd  = rd;
        e.val = val;
        e.fl  = fl;
        e.lat = lat;
        return e;
    endfunction

    // lat == 0 marks an instruction that produces no writeback
    task automatic accept(input logic [31:0] ins, input exp_t e,
                          input bit hold);
        int n = 0;
        instr       = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_ready) begin
            check("accept_timeout", {31'd0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (!hold) instr_valid = 1'b0;
            if (e.lat > 0) sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int   n = 0;
        exp_t e;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 60);
        if (sb.size() == 0) begin
            check("sb_underflow", {31'd0, done}, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("latency_r%0d", e.rd), n, e.lat);
            check($sformatf("result_r%0d", e.rd), result, e.val);
            check($sformatf("flags_r%0d", e.rd), flags, e.fl);
            dbg_addr = e.rd;
            #1;
            check($sformatf("gpr_r%0d", e.rd), dbg_data, e.val);
            last_val = e.val;
            last_fl  = e.fl;
        end
    endtask

    task automatic run(input logic [31:0] ins, input logic [15:0] val,
                       input logic [3:0] fl, input int lat);
        accept(ins, mk(ins[26:22], val, fl, lat), 1'b0);
        wait_done();
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_sgpr", {16'd0, sgpr}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_after_edge", {31'd0, instr_ready}, 32'd1);

        run(fi(5'd1, 5'd2, 5'd0, 16'd4), 16'd4, 4'b0000, 1);
        run(fi(5'd2, 5'd0, 5'd2, 16'd4), 16'd8, 4'b0000, 1);

        run(fi(5'd1, 5'd1, 5'd0, 16'h7FFF), 16'h7FFF, 4'b0000, 1);
        run(fi(5'd1, 5'd2, 5'd0, 16'h0001), 16'h0001, 4'b0000, 1);
        run(fr(5'd2, 5'd3, 5'd1, 5'd2), 16'h8000, 4'b1001, 1);
        run(fr(5'd3, 5'd4, 5'd2, 5'd1), 16'h8002, 4'b1010, 1);

        run(fi(5'd1, 5'd2, 5'd0, 16'h0100), 16'h0100, 4'b0000, 1);
        run(fi(5'd1, 5'd5, 5'd0, 16'h0300), 16'h0300, 4'b0000, 1);
        run(fr(5'd4, 5'd4, 5'd2, 5'd5), 16'h0000, 4'b0110, 17);
        check("mul_sgpr", {16'd0, sgpr}, 32'h0003);
        run(fr(5'd0, 5'd6, 5'd0, 5'd0), 16'h0003, 4'b0000, 1);

        run(fi(5'd1, 5'd7, 5'd0, 16'h00F0), 16'h00F0, 4'b0000, 1);
        run(fi(5'd5, 5'd8, 5'd7, 16'h0F0F), 16'h0FFF, 4'b0000, 1);
        run(fi(5'd6, 5'd9, 5'd7, 16'h0F0F), 16'h0000, 4'b0100, 1);
        run(fi(5'd7, 5'd10, 5'd7, 16'h00FF), 16'h000F, 4'b0000, 1);
        run(fi(5'd8, 5'd11, 5'd7, 16'h00F0), 16'hFFFF, 4'b1000, 1);
        run(fi(5'd9, 5'd12, 5'd7, 16'h00F0), 16'hFF0F, 4'b1000, 1);
        run(fr(5'd10, 5'd13, 5'd7, 5'd0), 16'hFF07, 4'b1000, 1);
        run(fi(5'd11, 5'd14, 5'd0, 16'hFFFF), 16'h0000, 4'b0100, 1);
        run(fi(5'd2, 5'd15, 5'd12, 16'h00F1), 16'h0000, 4'b0110, 1);
        run(fr(5'd2, 5'd2, 5'd2, 5'd2), 16'h0200, 4'b0000, 1);

        // Back-to-back with valid held: r17 depends on r16
        accept(fi(5'd2, 5'd16, 5'd0, 16'd1), mk(5'd16, 16'd9, 4'b0000, 1),
               1'b1);
        instr = fr(5'd3, 5'd17, 5'd16, 5'd0);
        check("busy_ready", {31'd0, instr_ready}, 32'd0);
        wait_done();
        check("ready_at_done", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #1;
        sb.push_back(mk(5'd17, 16'd1, 4'b0000, 1));
        instr_valid = 1'b0;
        check("second_accepted", {31'd0, instr_ready}, 32'd0);
        check("done_pulse_a", {31'd0, done}, 32'd0);
        wait_done();
        @(posedge clk); #1;
        check("done_pulse_b", {31'd0, done}, 32'd0);
        check("no_dup_accept", {31'd0, instr_ready}, 32'd1);

        accept(fi(5'd15, 5'd3, 5'd1, 16'h1234), mk(5'd3, 16'd0, 4'd0, 0),
               1'b0);
        dbg_addr = 5'd3;
        @(posedge clk); #1;
        check("illegal_pulse", {31'd0, illegal}, 32'd1);
        check("illegal_no_done", {31'd0, done}, 32'd0);
        check("illegal_ready", {31'd0, instr_ready}, 32'd1);
        check("illegal_result", {16'd0, result}, {16'd0, last_val});
        check("illegal_flags", {28'd0, flags}, {28'd0, last_fl});
        check("illegal_gpr", {16'd0, dbg_data}, 32'h8000);
        @(posedge clk); #1;
        check("illegal_width", {31'd0, illegal}, 32'd0);

        accept(fr(5'd4, 5'd18, 5'd1, 5'd1), mk(5'd18, 16'h0001, 4'b0010, 17),
               1'b0);
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("mul_busy_no_done", n, 0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_ready", {31'd0, instr_ready}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sgpr", {16'd0, sgpr}, 32'd0);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_flags", {28'd0, flags}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("abort_gpr%0d", i), {16'd0, dbg_data}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("release_ready_low", {31'd0, instr_ready}, 32'd0);
        @(posedge clk); #1;
        check("release_ready_high", {31'd0, instr_ready}, 32'd1);
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("abort_no_done", n, 0);

        run(fi(5'd1, 5'd1, 5'd0, 16'd5), 16'd5, 4'b0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
